bcd_unit_counter: RTL and testbench

//  Parametrised time/calendar unit counter that counts directly in packed BCD.
//  No binary counter or binary-to-BCD converter is used.
//  One instance per clock/calendar field (sec, min, hour, day, month), chained

---
 rtl/bcd_unit_counter.sv | 204 ++++++++++++++++++++
 tb/tb_bcd_unit_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_unit_counter.sv
// Packed-BCD time/calendar unit counter with tick-enabled RUN mode and a SET mode driven by synchronised inc/dec keys.
// Optional blink output for SET mode is built when SET_BLINK_EN is defined (adds blink_tick/blank ports).
module bcd_unit_counter #(
  parameter int MODULO    = 60,
  parameter int DIGITS    = 2,
  parameter int MIN_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick_in,
  input  logic                  set,
  input  logic                  inc_key,
  input  logic                  dec_key,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  carry,
  output logic                  setting
`ifdef SET_BLINK_EN
  ,
  input  logic                  blink_tick,
  output logic                  blank
`endif
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VALUE);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MIN_VALUE + MODULO - 1);

  if (MODULO < 1 || MIN_VALUE < 0 || (MIN_VALUE + MODULO - 1) >= pow10(DIGITS)) begin : g_param_check
    $error("bcd_unit_counter: MODULO/MIN_VALUE range does not fit in DIGITS BCD digits");
  end

  // Digit-serial ripple: each digit rolls 9->0 and passes the +1 upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t state_q, state_next;

  logic set_s1, set_s2;
  logic inc_s1, inc_s2, inc_d;
  logic dec_s1, dec_s2, dec_d;
  logic inc_ev, dec_ev;

  logic [W-1:0] count_q, count_next;
  logic         carry_q, carry_next;

  // The state register doubles as the third (edge) flop of the set chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_s1 <= 1'b0;
      set_s2 <= 1'b0;
      inc_s1 <= 1'b0;
      inc_s2 <= 1'b0;
      inc_d  <= 1'b0;
      dec_s1 <= 1'b0;
      dec_s2 <= 1'b0;
      dec_d  <= 1'b0;
    end else begin
      set_s1 <= set;
      set_s2 <= set_s1;
      inc_s1 <= inc_key;
      inc_s2 <= inc_s1;
      inc_d  <= inc_s2;
      dec_s1 <= dec_key;
      dec_s2 <= dec_s1;
      dec_d  <= dec_s2;
    end
  end

  assign inc_ev = inc_s2 & ~inc_d;
  assign dec_ev = dec_s2 & ~dec_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    if (set_s2) state_next = ST_SET;
    else        state_next = ST_RUN;
  end

  assign setting = (state_q == ST_SET);

  // Mode handling follows the current (old) state on the switching cycle.
  always_comb begin
    count_next = count_q;
    carry_next = 1'b0;
    if (clear) begin
      count_next = MIN_BCD;
    end else if (state_q == ST_RUN) begin
      if (tick_in) begin
        if (count_q == MAX_BCD) begin
          count_next = MIN_BCD;
          carry_next = 1'b1;
        end else begin
          count_next = bcd_inc(count_q);
        end
      end
    end else begin
      if (inc_ev && !dec_ev) begin
        count_next = (count_q == MAX_BCD) ? MIN_BCD : bcd_inc(count_q);
      end else if (dec_ev && !inc_ev) begin
        count_next = (count_q == MIN_BCD) ? MAX_BCD : bcd_dec(count_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= MIN_BCD;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_next;
      carry_q <= carry_next;
    end
  end

  assign count_bcd = count_q;
  assign carry     = carry_q;

`ifdef SET_BLINK_EN
  logic blank_q, blank_next;

  // Blank only toggles while staying in SET; entering, leaving or a key press shows the digits.
  always_comb begin
    blank_next = blank_q;
    if (state_q != ST_SET || state_next != ST_SET) begin
      blank_next = 1'b0;
    end else if (inc_ev || dec_ev) begin
      blank_next = 1'b0;
    end else if (blink_tick) begin
      blank_next = ~blank_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) blank_q <= 1'b0;
    else        blank_q <= blank_next;
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_unit_counter.sv
// Directed bench for bcd_unit_counter: a seconds-style instance (0..59) and a month-style instance (1..12).
// Expected values are queued as stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_bcd_unit_counter;

  logic       clock;
  logic       reset;

  logic       a_tick, a_set, a_inc, a_dec, a_clear;
  logic [7:0] a_count;
  logic       a_carry, a_setting;

  logic       b_tick, b_set, b_inc, b_dec, b_clear;
  logic [7:0] b_count;
  logic       b_carry, b_setting;

`ifdef SET_BLINK_EN
  logic       a_blink_tick, a_blank;
  logic       b_blink_tick, b_blank;
`endif

  logic [15:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  bcd_unit_counter #(.MODULO(60), .DIGITS(2), .MIN_VALUE(0)) u_sec (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (a_tick),
    .set       (a_set),
    .inc_key   (a_inc),
    .dec_key   (a_dec),
    .clear     (a_clear),
    .count_bcd (a_count),
    .carry     (a_carry),
    .setting   (a_setting)
`ifdef SET_BLINK_EN
    ,
    .blink_tick(a_blink_tick),
    .blank     (a_blank)
`endif
  );

  bcd_unit_counter #(.MODULO(12), .DIGITS(2), .MIN_VALUE(1)) u_month (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (b_tick),
    .set       (b_set),
    .inc_key   (b_inc),
    .dec_key   (b_dec),
    .clear     (b_clear),
    .count_bcd (b_count),
    .carry     (b_carry),
    .setting   (b_setting)
`ifdef SET_BLINK_EN
    ,
    .blink_tick(b_blink_tick),
    .blank     (b_blank)
`endif
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard check: pops the oldest expected value and compares it to the observation.
  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic a_ticks(input int n);
    a_tick = 1'b1;
    cycles(n);
    a_tick = 1'b0;
  endtask

  task automatic b_ticks(input int n);
    b_tick = 1'b1;
    cycles(n);
    b_tick = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    a_tick = 1'b0; a_set = 1'b0; a_inc = 1'b0; a_dec = 1'b0; a_clear = 1'b0;
    b_tick = 1'b0; b_set = 1'b0; b_inc = 1'b0; b_dec = 1'b0; b_clear = 1'b0;
`ifdef SET_BLINK_EN
    a_blink_tick = 1'b0;
    b_blink_tick = 1'b0;
`endif

    // Reset values
    #12;
    exp_q.push_back(16'h0000); check("rst_a_count", {8'h00, a_count});
    exp_q.push_back(16'h0000); check("rst_a_carry_setting", {14'h0, a_carry, a_setting});
    exp_q.push_back(16'h0001); check("rst_b_count", {8'h00, b_count});
    @(negedge clock);
    reset = 1'b1;

    // Reset mid-count acts immediately, then the counter holds at 00
    a_ticks(5);
    exp_q.push_back(16'h0005); check("run_5_ticks", {8'h00, a_count});
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'h0000); check("async_rst_count", {8'h00, a_count});
    exp_q.push_back(16'h0000); check("async_rst_carry_setting", {14'h0, a_carry, a_setting});
    @(negedge clock);
    reset = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0000); check("post_rst_hold", {8'h00, a_count});

    // Seconds wrap 58 -> 59 -> 00 with a one-cycle carry
    a_ticks(58);
    exp_q.push_back(16'h0058); check("cnt_58", {8'h00, a_count});
    a_ticks(1);
    exp_q.push_back(16'h0059); check("cnt_59", {8'h00, a_count});
    exp_q.push_back(16'h0000); check("no_carry_59", {15'h0, a_carry});
    a_ticks(1);
    exp_q.push_back(16'h0000); check("wrap_00", {8'h00, a_count});
    exp_q.push_back(16'h0001); check("carry_hi", {15'h0, a_carry});
    cycles(1);
    exp_q.push_back(16'h0000); check("carry_one_cycle", {15'h0, a_carry});

    // Month range 01..12: wrap on tick, wrap downward on dec in SET
    b_ticks(11);
    exp_q.push_back(16'h0012); check("month_12", {8'h00, b_count});
    b_ticks(1);
    exp_q.push_back(16'h0001); check("month_wrap_01", {8'h00, b_count});
    exp_q.push_back(16'h0001); check("month_carry", {15'h0, b_carry});
    b_set = 1'b1;
    cycles(2);
    exp_q.push_back(16'h0000); check("month_set_n1", {15'h0, b_setting});
    cycles(1);
    exp_q.push_back(16'h0001); check("month_set_n2", {15'h0, b_setting});
    b_dec = 1'b1;
    cycles(2);
    exp_q.push_back(16'h0001); check("month_dec_n1", {8'h00, b_count});
    cycles(1);
    exp_q.push_back(16'h0012); check("month_dec_wrap", {8'h00, b_count});
    exp_q.push_back(16'h0000); check("month_dec_no_carry", {15'h0, b_carry});
    b_dec = 1'b0;
    cycles(3);

    // Held inc key in SET: one step at edge N+2, ticks ignored
    a_ticks(9);
    exp_q.push_back(16'h0009); check("sec_09", {8'h00, a_count});
    a_set = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0001); check("sec_setting", {15'h0, a_setting});
    a_inc  = 1'b1;
    a_tick = 1'b1;
    cycles(2);
    exp_q.push_back(16'h0009); check("inc_n1_tick_ignored", {8'h00, a_count});
    cycles(1);
    exp_q.push_back(16'h0010); check("inc_step_10", {8'h00, a_count});
    cycles(17);
    exp_q.push_back(16'h0010); check("inc_held_one_step", {8'h00, a_count});
    a_inc  = 1'b0;
    a_tick = 1'b0;
    cycles(3);

    // Simultaneous inc/dec events cancel
    a_inc = 1'b1;
    a_dec = 1'b1;
    cycles(5);
    exp_q.push_back(16'h0010); check("inc_dec_cancel", {8'h00, a_count});
    a_inc = 1'b0;
    a_dec = 1'b0;
    cycles(3);

    // Decrement borrows across digits, clear in SET, dec wrap 00 -> 59, inc wrap without carry
    a_dec = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0009); check("dec_borrow_09", {8'h00, a_count});
    a_dec = 1'b0;
    cycles(3);
    a_clear = 1'b1;
    cycles(1);
    a_clear = 1'b0;
    exp_q.push_back(16'h0000); check("clear_in_set", {8'h00, a_count});
    a_dec = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0059); check("dec_wrap_59", {8'h00, a_count});
    a_dec = 1'b0;
    cycles(3);
    a_inc = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0000); check("inc_wrap_00", {8'h00, a_count});
    exp_q.push_back(16'h0000); check("set_wrap_no_carry", {15'h0, a_carry});
    a_inc = 1'b0;
    cycles(3);
    a_set = 1'b0;
    cycles(3);
    exp_q.push_back(16'h0000); check("back_to_run", {15'h0, a_setting});

    // Clear beats a tick on the top value and suppresses carry
    a_ticks(59);
    exp_q.push_back(16'h0059); check("run_59", {8'h00, a_count});
    a_clear = 1'b1;
    a_tick  = 1'b1;
    cycles(1);
    a_clear = 1'b0;
    a_tick  = 1'b0;
    exp_q.push_back(16'h0000); check("clear_over_tick", {8'h00, a_count});
    exp_q.push_back(16'h0000); check("clear_no_carry", {15'h0, a_carry});
    cycles(1);
    exp_q.push_back(16'h0000); check("clear_no_carry_next", {15'h0, a_carry});

`ifdef SET_BLINK_EN
    // Blink toggling in SET, cleared by key events and on leaving SET
    a_set = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0000); check("blank_entry", {15'h0, a_blank});
    for (int i = 0; i < 3; i++) begin
      a_blink_tick = 1'b1;
      cycles(1);
      a_blink_tick = 1'b0;
      exp_q.push_back((i % 2 == 0) ? 16'h0001 : 16'h0000);
      check("blank_toggle", {15'h0, a_blank});
      cycles(1);
    end
    a_inc = 1'b1;
    cycles(3);
    exp_q.push_back(16'h0000); check("blank_key_clear", {15'h0, a_blank});
    a_inc = 1'b0;
    cycles(3);
    a_blink_tick = 1'b1;
    cycles(1);
    a_blink_tick = 1'b0;
    exp_q.push_back(16'h0001); check("blank_again", {15'h0, a_blank});
    a_set = 1'b0;
    cycles(3);
    exp_q.push_back(16'h0000); check("blank_run", {15'h0, a_blank});
    exp_q.push_back(16'h0000); check("blank_b_idle", {15'h0, b_blank});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
